ysyx_23060061_axil_sram: RTL and testbench
==========================================

YSYX_23060061_AXIL_SRAM -- requirements
Module: ysyx_23060061_axil_sram

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, width of awaddr/araddr.
REQ-002 Parameter DATA_WIDTH, default 32, width of wdata/rdata; legal values 32 and 64.
REQ-003 Parameter DEPTH, default 1024, number of DATA_WIDTH-bit words stored; power of two.
REQ-004 Parameter BASE_ADDR, default 32'h8000_0000, byte address of word 0.
REQ-005 Parameter RD_LAT, default 1, cycles from AR handshake to rvalid; range 1..15.
REQ-006 Parameter WR_LAT, default 1, cycles from last of AW/W handshakes to bvalid; range 1..15.
REQ-007 clk  in  1  single clock; all state changes on rising edge.
REQ-008 rst  in  1  reset, asynchronous assert, active-high; synchronous release is the driver's job.
REQ-009 araddr in ADDR_WIDTH; arvalid in 1; arready out 1: read address channel.
REQ-010 rdata out DATA_WIDTH; rresp out 2; rvalid out 1; rready in 1: read data channel.
REQ-011 awaddr in ADDR_WIDTH; awvalid in 1; awready out 1: write address channel.
REQ-012 wdata in DATA_WIDTH; wstrb in DATA_WIDTH/8; wvalid in 1; wready out 1: write data channel.
REQ-013 bresp out 2; bvalid out 1; bready in 1: write response channel.

Function
REQ-014 Storage: internal array DEPTH x DATA_WIDTH; no DPI access; contents not reset.
REQ-015 Index = (addr - BASE_ADDR) >> log2(DATA_WIDTH/8); byte-offset bits ignored.
REQ-016 Address out of range (addr < BASE_ADDR or index >= DEPTH): resp 2'b10 SLVERR, rdata all-zero, no array write; in range: resp 2'b00 OKAY.
REQ-017 Read and write paths are independent FSMs and may be busy concurrently.
REQ-018 Read FSM states R_IDLE, R_WAIT, R_RESP; arready = 1 only in R_IDLE.
REQ-019 AR handshake at edge N: capture araddr, enter R_WAIT, load counter RD_LAT-1; counter reaching 0 -> array sampled, rvalid = 1 from edge N+RD_LAT, state R_RESP.
REQ-020 R_RESP: rdata/rresp stable while rvalid && !rready; on rvalid && rready -> rvalid 0, R_IDLE, arready 1 next cycle (one read outstanding max).
REQ-021 Write FSM states W_IDLE, W_WAIT, W_RESP; AW and W accepted independently in any order or same cycle in W_IDLE.
REQ-022 awready = 1 in W_IDLE until AW captured, then 0; wready likewise for W; both 0 outside W_IDLE.
REQ-023 When both captured (edge M = later handshake) -> W_WAIT, counter WR_LAT-1; at expiry array bytes with wstrb[i]=1 updated, bvalid = 1 from edge M+WR_LAT, state W_RESP.
REQ-024 W_RESP: bresp stable while bvalid && !bready; on handshake -> bvalid 0, W_IDLE, awready/wready 1 next cycle.
REQ-025 wstrb = 0 in range: no bytes change, bresp OKAY.
REQ-026 Same-word read sample and write commit on same edge: read returns pre-write data.
REQ-027 Inputs arriving with valid while the matching ready is 0 are ignored (no capture).

Reset
REQ-028 While rst = 1: rvalid, bvalid = 0; rdata = 0; rresp, bresp = 2'b00; arready, awready, wready = 1; FSMs in R_IDLE/W_IDLE; counters and captured flags cleared.
REQ-029 Reset asserted mid-transaction aborts it immediately; a write not yet committed leaves the array unchanged.
REQ-030 No handshake is recognised on an edge where rst = 1.

Verification
REQ-031 Defaults, RD_LAT=3: write 0xDEADBEEF to 0x8000_0010 wstrb 0xF, read same -> rvalid at AR edge+3, rdata 0xDEADBEEF, rresp 00.
REQ-032 wstrb 0x3 writing 0x1234_5678 over 0xDEADBEEF -> readback 0xDEAD5678.
REQ-033 W handshake 4 cycles before AW, WR_LAT=2 -> bvalid exactly 2 cycles after AW handshake; bready held 0 for 5 cycles -> bvalid, bresp stable throughout.
REQ-034 Read 0x7FFF_FFFC and 0x8000_1000 (DEPTH=1024, 32-bit) -> rresp 10, rdata 0; write there -> bresp 10, word 0 unchanged.
REQ-035 Concurrent read and write to same word, read sample coinciding with commit -> old value returned; next read returns new value.
REQ-036 rst pulsed during W_WAIT -> bvalid 0, all readies 1, subsequent read returns prior contents.

Source files
------------

// File: rtl/ysyx_23060061_axil_sram.sv
// ysyx_23060061_axil_sram: AXI4-Lite SRAM slave.
// Independent read/write FSMs with fixed, parameterised access latency.
module ysyx_23060061_axil_sram #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 32'h8000_0000,
    parameter int RD_LAT = 1,
    parameter int WR_LAT = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rvalid,
    input  logic                    rready,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int BSH = $clog2(NB);
    localparam int IW = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);
    localparam logic [3:0] RD_CNT = 4'(RD_LAT - 1);
    localparam logic [3:0] WR_CNT = 4'(WR_LAT - 1);
    localparam logic [1:0] OKAY = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return (a >= BASE_ADDR) && (((a - BASE_ADDR) >> BSH) < DEPTH_A);
    endfunction

    function automatic logic [IW-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
        return IW'((a - BASE_ADDR) >> BSH);
    endfunction

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;

    r_state_t              r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [3:0]            r_cnt;
    logic                  r_hit;
    logic [IW-1:0]         r_idx;

    w_state_t              w_state;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_data;
    logic [NB-1:0]         w_strb;
    logic [3:0]            w_cnt;
    logic                  aw_got;
    logic                  w_got;
    logic                  w_hit;
    logic [IW-1:0]         w_idx;
    logic                  aw_hs;
    logic                  w_hs;
    logic                  mem_we;

    assign r_hit = in_range(r_addr);
    assign r_idx = word_idx(r_addr);
    assign w_hit = in_range(w_addr);
    assign w_idx = word_idx(w_addr);
    assign aw_hs = awvalid && awready;
    assign w_hs = wvalid && wready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= R_IDLE;
            r_addr  <= '0;
            r_cnt   <= '0;
            arready <= 1'b1;
            rvalid  <= 1'b0;
            rdata   <= '0;
            rresp   <= OKAY;
        end else begin
            unique case (r_state)
                R_IDLE: begin
                    if (arvalid && arready) begin
                        r_addr  <= araddr;
                        r_cnt   <= RD_CNT;
                        arready <= 1'b0;
                        r_state <= R_WAIT;
                    end
                end
                R_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        rdata   <= r_hit ? mem[r_idx] : '0;
                        rresp   <= r_hit ? OKAY : SLVERR;
                        rvalid  <= 1'b1;
                        r_state <= R_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                R_RESP: begin
                    if (rready) begin
                        rvalid  <= 1'b0;
                        arready <= 1'b1;
                        r_state <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state <= W_IDLE;
            w_addr  <= '0;
            w_data  <= '0;
            w_strb  <= '0;
            w_cnt   <= '0;
            aw_got  <= 1'b0;
            w_got   <= 1'b0;
            awready <= 1'b1;
            wready  <= 1'b1;
            bvalid  <= 1'b0;
            bresp   <= OKAY;
        end else begin
            unique case (w_state)
                W_IDLE: begin
                    if (aw_hs) begin
                        w_addr  <= awaddr;
                        aw_got  <= 1'b1;
                        awready <= 1'b0;
                    end
                    if (w_hs) begin
                        w_data <= wdata;
                        w_strb <= wstrb;
                        w_got  <= 1'b1;
                        wready <= 1'b0;
                    end
                    if ((aw_got || aw_hs) && (w_got || w_hs)) begin
                        w_cnt   <= WR_CNT;
                        awready <= 1'b0;
                        wready  <= 1'b0;
                        w_state <= W_WAIT;
                    end
                end
                W_WAIT: begin
                    if (w_cnt == 4'd0) begin
                        bresp   <= w_hit ? OKAY : SLVERR;
                        bvalid  <= 1'b1;
                        w_state <= W_RESP;
                    end else begin
                        w_cnt <= w_cnt - 4'd1;
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid  <= 1'b0;
                        aw_got  <= 1'b0;
                        w_got   <= 1'b0;
                        awready <= 1'b1;
                        wready  <= 1'b1;
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Commit on the same edge bvalid rises; a reset before then drops it.
    assign mem_we = !rst && (w_state == W_WAIT) && (w_cnt == 4'd0) && w_hit;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < NB; i++) begin
                if (w_strb[i]) mem[w_idx][8*i +: 8] <= w_data[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_ysyx_23060061_axil_sram.sv
// tb_ysyx_23060061_axil_sram: directed checks of the AXI4-Lite SRAM.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_ysyx_23060061_axil_sram;
    localparam int RDL = 3;
    localparam int WRL = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [31:0] d;
    logic [1:0]  resp;
    int          lat;
    int          n;
    int          edge_m;
    logic        stable;
    logic        got_r;
    logic        got_b;

    ysyx_23060061_axil_sram #(
        .RD_LAT(RDL),
        .WR_LAT(WRL)
    ) dut (
        .clk(clk), .rst(rst),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] dat,
                            input logic [3:0] s, output logic [1:0] r,
                            output int l);
        int k;
        int em;
        logic ah;
        logic wh;
        @(negedge clk);
        awaddr = a; wdata = dat; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        k = 0; em = 0;
        while ((awvalid || wvalid) && k < 20) begin
            ah = awvalid && awready;
            wh = wvalid && wready;
            if (ah || wh) em = cyc + 1;
            @(negedge clk);
            if (ah) awvalid = 1'b0;
            if (wh) wvalid = 1'b0;
            k++;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        k = 0;
        while (!bvalid && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!bvalid) check("b_timeout", 0, 1);
        l = cyc - em;
        r = bresp;
        @(negedge clk);
        bready = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] dat,
                           output logic [1:0] r, output int l);
        int k;
        int ea;
        @(negedge clk);
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        k = 0;
        while (!arready && k < 20) begin
            @(negedge clk);
            k++;
        end
        ea = cyc + 1;
        @(negedge clk);
        arvalid = 1'b0;
        k = 0;
        while (!rvalid && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!rvalid) check("r_timeout", 0, 1);
        l = cyc - ea;
        dat = rdata;
        r = rresp;
        @(negedge clk);
        rready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        araddr = '0; arvalid = 0; rready = 0;
        awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0;
        bready = 0;
        repeat (3) @(negedge clk);
        check("rst_rvalid", rvalid, 0);
        check("rst_bvalid", bvalid, 0);
        check("rst_rdata", rdata, 0);
        check("rst_rresp", rresp, 0);
        check("rst_bresp", bresp, 0);
        check("rst_arready", arready, 1);
        check("rst_awready", awready, 1);
        check("rst_wready", wready, 1);
        rst = 1'b0;

        do_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, resp, lat);
        check("wr1_bresp", resp, 2'b00);
        check("wr1_lat", lat, WRL);
        do_read(32'h8000_0010, d, resp, lat);
        check("rd1_lat", lat, RDL);
        check("rd1_data", d, 32'hDEAD_BEEF);
        check("rd1_rresp", resp, 2'b00);

        do_write(32'h8000_0012, 32'h1234_5678, 4'h3, resp, lat);
        check("wr2_bresp", resp, 2'b00);
        do_read(32'h8000_0010, d, resp, lat);
        check("rd2_strb", d, 32'hDEAD_5678);

        // W four cycles ahead of AW, then back-pressure on B
        @(negedge clk);
        wdata = 32'hCAFE_F00D; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b0;
        @(negedge clk);
        wvalid = 1'b0;
        check("w_only_wready", wready, 0);
        check("w_only_awready", awready, 1);
        repeat (3) @(negedge clk);
        awaddr = 32'h8000_0020; awvalid = 1'b1;
        edge_m = cyc + 1;
        @(negedge clk);
        awvalid = 1'b0;
        check("aw_late_awready", awready, 0);
        n = 0;
        while (!bvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bvalid) check("b_timeout_late", 0, 1);
        check("b_lat_aw_late", cyc - edge_m, WRL);
        awvalid = 1'b1; wvalid = 1'b1; wdata = 32'h0;
        stable = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (!bvalid || bresp !== 2'b00) stable = 1'b0;
        end
        check("b_hold_stable", stable, 1);
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        check("b_done_bvalid", bvalid, 0);
        check("b_done_awready", awready, 1);
        check("b_done_wready", wready, 1);
        do_read(32'h8000_0020, d, resp, lat);
        check("rd_late_w", d, 32'hCAFE_F00D);

        do_write(32'h8000_0000, 32'h0BAD_F00D, 4'hF, resp, lat);
        check("wr0_bresp", resp, 2'b00);
        do_read(32'h7FFF_FFFC, d, resp, lat);
        check("oor_lo_rresp", resp, 2'b10);
        check("oor_lo_rdata", d, 0);
        do_read(32'h8000_1000, d, resp, lat);
        check("oor_hi_rresp", resp, 2'b10);
        check("oor_hi_rdata", d, 0);
        do_write(32'h8000_1000, 32'hFFFF_FFFF, 4'hF, resp, lat);
        check("oor_hi_bresp", resp, 2'b10);
        do_write(32'h7FFF_FFFC, 32'hFFFF_FFFF, 4'hF, resp, lat);
        check("oor_lo_bresp", resp, 2'b10);
        do_write(32'h8000_0000, 32'hFFFF_FFFF, 4'h0, resp, lat);
        check("strb0_bresp", resp, 2'b00);
        do_read(32'h8000_0000, d, resp, lat);
        check("word0_kept", d, 32'h0BAD_F00D);

        // AR one edge before AW/W: read sample lands on the commit edge
        @(negedge clk);
        araddr = 32'h8000_0010; arvalid = 1'b1; rready = 1'b1; bready = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        awaddr = 32'h8000_0010; wdata = 32'h1111_2222; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0; got_r = 1'b0; got_b = 1'b0; d = '0;
        while (!(got_r && got_b) && n < 20) begin
            if (rvalid && !got_r) begin
                got_r = 1'b1;
                d = rdata;
            end
            if (bvalid && !got_b) got_b = 1'b1;
            @(negedge clk);
            n++;
        end
        rready = 1'b0; bready = 1'b0;
        check("conc_both_done", got_r && got_b, 1);
        check("conc_old_data", d, 32'hDEAD_5678);
        do_read(32'h8000_0010, d, resp, lat);
        check("conc_new_data", d, 32'h1111_2222);

        // reset while the write is waiting to commit
        @(negedge clk);
        awaddr = 32'h8000_0010; wdata = 32'h5555_5555; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        rst = 1'b1;
        #1;
        check("mid_rst_bvalid", bvalid, 0);
        check("mid_rst_awready", awready, 1);
        check("mid_rst_wready", wready, 1);
        check("mid_rst_arready", arready, 1);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_bvalid", bvalid, 0);
        bready = 1'b0;
        do_read(32'h8000_0010, d, resp, lat);
        check("post_rst_data", d, 32'h1111_2222);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end
endmodule
